// File: rtl/segment_7_pkg.sv
// Shared constants for the hexadecimal 7-segment decoder: glyph table,
// segment bit positions and the active-high blank pattern.
package segment_7_pkg;

  // Segment bit positions within the 8-bit drive word
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high glyph codes, bits g..a, indexed by nibble.
  // 6 and 9 carry tails, 7 omits segment f, letters render as A b C d E F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // All segments off, before any polarity inversion
  localparam logic [7:0] BLANK = 8'h00;

endpackage

// File: rtl/segment_7_lut.sv
// Combinational nibble to active-high 7-segment glyph lookup.
module segment_7_lut
  import segment_7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);

  // Table lookup; every nibble has a defined glyph
  always_comb begin
    glyph = GLYPH[bcd];
  end

endmodule

// File: rtl/segment_7.sv
// Registered hex-to-7-segment decoder with decimal point, enable blanking
// and selectable common-cathode / common-anode output polarity.
module segment_7
  import segment_7_pkg::*;
#(
  parameter bit COMMON_ANODE = 1'b0
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       en,
  output logic [7:0] seg
);

  logic [6:0] glyph;
  logic [7:0] active_high;
  logic [7:0] next_seg;
  logic [7:0] blank_pat;

  segment_7_lut u_lut (
    .bcd   (bcd),
    .glyph (glyph)
  );

  // Gate glyph and dp with enable, then apply output polarity
  always_comb begin
    active_high = BLANK;
    if (en) begin
      active_high[SEG_G:SEG_A] = glyph;
      active_high[SEG_DP]      = dp;
    end
    next_seg  = COMMON_ANODE ? ~active_high : active_high;
    blank_pat = COMMON_ANODE ? ~BLANK : BLANK;
  end

  // Output register; reset loads the polarity-adjusted blank pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= blank_pat;
    end else begin
      seg <= next_seg;
    end
  end

endmodule

// File: tb/tb_segment_7.sv
// Self-checking bench for segment_7: one common-cathode and one common-anode
// instance share stimulus; expected codes are queued at drive time and
// checked one edge later.
module tb_segment_7;

  logic       clk;
  logic       rst;
  logic [3:0] bcd;
  logic       dp;
  logic       en;
  logic [7:0] seg_cc;
  logic [7:0] seg_ca;

  logic [7:0] q_cc [$];
  logic [7:0] q_ca [$];

  int unsigned vectors;
  int unsigned miscompares;

  segment_7 #(.COMMON_ANODE(1'b0)) dut_cc (
    .clk (clk), .rst (rst), .bcd (bcd), .dp (dp), .en (en), .seg (seg_cc)
  );

  segment_7 #(.COMMON_ANODE(1'b1)) dut_ca (
    .clk (clk), .rst (rst), .bcd (bcd), .dp (dp), .en (en), .seg (seg_ca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;
      4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;
      4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;
      4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] ref_cc(input logic r, input logic [3:0] b,
                                        input logic d, input logic e);
    if (r || !e) return 8'h00;
    return {d, ref_glyph(b)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] b,
                      input logic d, input logic e);
    logic [7:0] exp_cc;
    logic [7:0] exp_ca;
    rst = r; bcd = b; dp = d; en = e;
    q_cc.push_back(ref_cc(r, b, d, e));
    q_ca.push_back(~ref_cc(r, b, d, e));
    @(posedge clk);
    #1;
    if (q_cc.size() == 0 || q_ca.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      exp_cc = q_cc.pop_front();
      exp_ca = q_ca.pop_front();
      check({tag, "_cc"}, seg_cc, exp_cc);
      check({tag, "_ca"}, seg_ca, exp_ca);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; bcd = 4'h8; dp = 1'b1; en = 1'b1;

    // Reset priority over en/dp/bcd, then release
    step("reset0", 1'b1, 4'h8, 1'b1, 1'b1);
    step("reset1", 1'b1, 4'h8, 1'b1, 1'b1);
    check("reset_cc_const", seg_cc, 8'h00);
    check("reset_ca_const", seg_ca, 8'hFF);
    step("release", 1'b0, 4'h8, 1'b1, 1'b1);
    check("release_cc_const", seg_cc, 8'hFF);

    // Full nibble sweep
    for (int i = 0; i < 16; i++) begin
      step("sweep", 1'b0, 4'(i), 1'b0, 1'b1);
    end

    // Decimal point
    step("dp_on", 1'b0, 4'h1, 1'b1, 1'b1);
    check("dp_on_const", seg_cc, 8'h86);
    step("dp_off", 1'b0, 4'h1, 1'b0, 1'b1);
    check("dp_off_const", seg_cc, 8'h06);

    // Enable blanking including dp
    step("en1", 1'b0, 4'h8, 1'b1, 1'b1);
    step("en0", 1'b0, 4'h8, 1'b1, 1'b0);
    check("en0_ca_const", seg_ca, 8'hFF);
    step("en1b", 1'b0, 4'h8, 1'b1, 1'b1);

    // Common-anode specific codes
    step("ca_zero", 1'b0, 4'h0, 1'b0, 1'b1);
    check("ca_zero_const", seg_ca, 8'hC0);
    step("ca_f_dp", 1'b0, 4'hF, 1'b1, 1'b1);
    check("ca_f_dp_const", seg_ca, 8'h0E);

    // Reset together with en=0 and dp=1 gives the same blank
    step("rst_en0", 1'b1, 4'h3, 1'b1, 1'b0);

    // Mid-sweep single-cycle reset at bcd=5
    for (int i = 0; i < 5; i++) begin
      step("sweep2", 1'b0, 4'(i), 1'b0, 1'b1);
    end
    step("mid_rst", 1'b1, 4'h5, 1'b0, 1'b1);
    check("mid_rst_const", seg_cc, 8'h00);
    step("resume", 1'b0, 4'h5, 1'b0, 1'b1);
    check("resume_const", seg_cc, 8'h6D);
    for (int i = 6; i < 16; i++) begin
      step("sweep2", 1'b0, 4'(i), 1'b0, 1'b1);
    end

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the bench cannot hang
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
